covariance_accumulator: RTL

Streaming front end for the eigen-decomposition stage. It accepts one SIZE_N-channel ECG sample vector per handshake and accumulates first- and second-order sums over a window of 2^LOG2_SAMPLES vectors. At the end of each window it produces the symmetric SIZE_N x SIZE_N covariance matrix. The matrix is held stable on integer outputs, ready for direct connection to the eigenvalue-decomposition matrix input.

---
 rtl/covariance_accumulator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/covariance_accumulator.sv
// Streaming covariance front end: accumulates first/second-order sums over 2^LOG2_SAMPLES
// vectors, then finalises a symmetric SIZE_N x SIZE_N matrix. Define COV_MEAN_REMOVAL_EN for mean removal.
module covariance_accumulator #(
    parameter int SIZE_N       = 8,
    parameter int LOG2_SAMPLES = 8,
    parameter int SAMPLE_W     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SIZE_N-1:0][SAMPLE_W-1:0]     sample_in,
    input  logic                                sample_valid,
    output logic                                sample_ready,
    output logic [SIZE_N-1:0][SIZE_N-1:0][31:0] cov_matrix,
    output logic                                cov_valid,
    output logic [15:0]                         window_count
);
    localparam int TRI   = SIZE_N * (SIZE_N + 1) / 2;
    localparam int IDX_W = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int TRI_W = (TRI > 1) ? $clog2(TRI) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE_N - 1);

    typedef enum logic {ACCUM, FINALISE} state_t;

    state_t                  r_state;
    logic [LOG2_SAMPLES-1:0] r_count;
    logic [IDX_W-1:0]        r_row;
    logic [IDX_W-1:0]        r_col;
    logic [TRI_W-1:0]        r_tri;
    logic                    r_cov_valid;
    logic [15:0]             r_window_count;
    logic signed [63:0]      r_sum   [SIZE_N];
    logic signed [63:0]      r_prod  [TRI];
    logic signed [31:0]      r_shadow[SIZE_N][SIZE_N];
    logic signed [31:0]      r_cov   [SIZE_N][SIZE_N];

    logic                    w_transfer;
    logic                    w_step;
    logic                    w_last_pair;
    logic signed [63:0]      w_sel_prod;
    logic signed [63:0]      w_full;
    logic signed [31:0]      w_result;

    function automatic logic signed [63:0] sext64(input logic [SAMPLE_W-1:0] a);
        return {{(64-SAMPLE_W){a[SAMPLE_W-1]}}, a};
    endfunction

    function automatic logic signed [63:0] mul_sext64(input logic [SAMPLE_W-1:0] a,
                                                      input logic [SAMPLE_W-1:0] b);
        logic signed [2*SAMPLE_W-1:0] v_a;
        logic signed [2*SAMPLE_W-1:0] v_b;
        logic signed [2*SAMPLE_W-1:0] v_p;
        v_a = {{SAMPLE_W{a[SAMPLE_W-1]}}, a};
        v_b = {{SAMPLE_W{b[SAMPLE_W-1]}}, b};
        v_p = v_a * v_b;
        return {{(64-2*SAMPLE_W){v_p[2*SAMPLE_W-1]}}, v_p};
    endfunction

    // Upper-triangle pairs are packed row-major, so pair (i,j) lives at this flat index.
    function automatic int tri_idx(input int i, input int j);
        return i * SIZE_N - (i * (i - 1)) / 2 + (j - i);
    endfunction

    assign sample_ready = rst && (r_state == ACCUM);
    assign w_transfer   = sample_valid && sample_ready;
    assign w_last_pair  = (r_row == LAST_IDX) && (r_col == LAST_IDX);
    assign w_sel_prod   = r_prod[r_tri];

`ifdef COV_MEAN_REMOVAL_EN
    logic               r_phase;
    logic signed [63:0] r_mean_prod;
    logic signed [63:0] w_mean;

    assign w_mean = r_mean_prod >>> LOG2_SAMPLES;
    assign w_full = (w_sel_prod - w_mean) >>> LOG2_SAMPLES;
    assign w_step = r_phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase     <= 1'b0;
            r_mean_prod <= '0;
        end else if (r_state == FINALISE) begin
            r_phase <= ~r_phase;
            if (!r_phase) r_mean_prod <= r_sum[r_row] * r_sum[r_col];
        end else begin
            r_phase <= 1'b0;
        end
    end
`else
    assign w_full = w_sel_prod >>> LOG2_SAMPLES;
    assign w_step = 1'b1;
`endif

    assign w_result = w_full[31:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ACCUM;
            r_count        <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_tri          <= '0;
            r_cov_valid    <= 1'b0;
            r_window_count <= '0;
            for (int i = 0; i < SIZE_N; i++) begin
                r_sum[i] <= '0;
                for (int j = 0; j < SIZE_N; j++) begin
                    r_shadow[i][j] <= '0;
                    r_cov[i][j]    <= '0;
                end
            end
            for (int k = 0; k < TRI; k++) r_prod[k] <= '0;
        end else begin
            r_cov_valid <= 1'b0;
            case (r_state)
                ACCUM: begin
                    if (w_transfer) begin
                        for (int i = 0; i < SIZE_N; i++) begin
                            r_sum[i] <= r_sum[i] + sext64(sample_in[i]);
                            for (int j = i; j < SIZE_N; j++)
                                r_prod[tri_idx(i, j)] <= r_prod[tri_idx(i, j)]
                                                         + mul_sext64(sample_in[i], sample_in[j]);
                        end
                        r_count <= r_count + LOG2_SAMPLES'(1);
                        if (&r_count) begin
                            r_state <= FINALISE;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_tri   <= '0;
                        end
                    end
                end
                FINALISE: begin
                    if (w_step) begin
                        r_shadow[r_row][r_col] <= w_result;
                        r_shadow[r_col][r_row] <= w_result;
                        r_tri <= r_tri + TRI_W'(1);
                        // Publish the whole matrix at once; the final pair bypasses the shadow.
                        if (w_last_pair) begin
                            for (int i = 0; i < SIZE_N; i++)
                                for (int j = 0; j < SIZE_N; j++)
                                    r_cov[i][j] <= r_shadow[i][j];
                            r_cov[r_row][r_col] <= w_result;
                            r_cov_valid    <= 1'b1;
                            r_window_count <= r_window_count + 16'd1;
                            r_state        <= ACCUM;
                            for (int i = 0; i < SIZE_N; i++) r_sum[i] <= '0;
                            for (int k = 0; k < TRI; k++) r_prod[k] <= '0;
                        end else if (r_col == LAST_IDX) begin
                            r_row <= r_row + IDX_W'(1);
                            r_col <= r_row + IDX_W'(1);
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    always_comb begin
        cov_matrix = '0;
        for (int i = 0; i < SIZE_N; i++)
            for (int j = 0; j < SIZE_N; j++)
                cov_matrix[i][j] = r_cov[i][j];
    end

    assign cov_valid    = r_cov_valid;
    assign window_count = r_window_count;

endmodule
